// File: rtl/alu.sv
// 32-bit execute-stage ALU: combinational result/zero plus a one-cycle
// registered copy (result_q, zero_q, out_valid) for pipelined consumers.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q,
    output logic             out_valid
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SLL  = 3'b001,
        OP_SLT  = 3'b010,
        OP_SLTU = 3'b011,
        OP_SUB  = 3'b100,
        OP_SRL  = 3'b101,
        OP_OR   = 3'b110,
        OP_AND  = 3'b111
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             vld;
    } out_s;

    logic [SHW-1:0] shamt;
    logic           lt_s;
    logic           lt_u;
    out_s           out_r;

    // Upper bits of right never reach the shifter, so a shift by WIDTH is a shift by 0.
    assign shamt = right[SHW-1:0];
    assign lt_s  = $signed(left) < $signed(right);
    assign lt_u  = left < right;

    always_comb begin
        result = '0;
        unique case (op_e'(opcode))
            OP_ADD:  result = left + right;
            OP_SLL:  result = left << shamt;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_u};
            OP_SUB:  result = left - right;
            OP_SRL:  result = left >> shamt;
            OP_OR:   result = left | right;
            OP_AND:  result = left & right;
        endcase
    end

    assign zero = (result == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= '0;
        end else begin
            out_r.vld <= in_valid;
            if (in_valid) begin
                out_r.res  <= result;
                out_r.zero <= zero;
            end
        end
    end

    assign result_q  = out_r.res;
    assign zero_q    = out_r.zero;
    assign out_valid = out_r.vld;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed boundary cases, registered path,
// asynchronous reset, and randomized ops against an arithmetic reference.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [2:0]  opcode;
    logic [31:0] left;
    logic [31:0] right;
    logic        in_valid;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;
    logic        out_valid;

    int vectors;
    int errors;

    alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .left(left), .right(right),
        .in_valid(in_valid), .result(result), .zero(zero),
        .result_q(result_q), .zero_q(zero_q), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on 64-bit values, reduced mod 2^32.
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint m;
        longint ua;
        longint ub;
        longint sh;
        longint r;
        m  = 64'h1_0000_0000;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sh = ub % 32;
        r  = 0;
        case (op)
            3'd0: r = (ua + ub) % m;
            3'd1: r = (ua * (64'd1 << sh)) % m;
            3'd2: r = (int'(a) < int'(b)) ? 1 : 0;
            3'd3: r = (ua < ub) ? 1 : 0;
            3'd4: r = (ua + m - ub) % m;
            3'd5: r = ua / (64'd1 << sh);
            3'd6: r = longint'({32'd0, a | b});
            default: r = longint'({32'd0, a & b});
        endcase
        return r[31:0];
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic v);
        opcode   = op;
        left     = a;
        right    = b;
        in_valid = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(3'd0, 32'd0, 32'd0, 1'b0);
        #2;
        vectors++;
        if (result_q !== 32'd0 || zero_q !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: result_q=%h zero_q=%b out_valid=%b want 0/0/0",
                     result_q, zero_q, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comb_directed();
        logic [2:0]  ops [12] = '{3'd0, 3'd7, 3'd4, 3'd0, 3'd4, 3'd4, 3'd2, 3'd3,
                                  3'd1, 3'd5, 3'd1, 3'd6};
        logic [31:0] las [12] = '{32'd4, 32'hC, 32'd7, 32'hFFFFFFFF, 32'd3, 32'd0,
                                  32'h80000000, 32'h80000000, 32'd1, 32'h80000000,
                                  32'd5, 32'hF0};
        logic [31:0] ras [12] = '{32'd3, 32'hA, 32'd3, 32'd1, 32'd3, 32'd1, 32'd1, 32'd1,
                                  32'd31, 32'd31, 32'd32, 32'h0F};
        logic [31:0] exp [12] = '{32'd7, 32'h8, 32'd4, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1,
                                  32'd0, 32'h80000000, 32'd1, 32'd5, 32'hFF};
        logic        expz;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(ops[i], las[i], ras[i], 1'b0);
            #1;
            expz = (exp[i] == 32'd0);
            vectors++;
            if (result !== exp[i] || zero !== expz) begin
                errors++;
                $display("FAIL comb_case%0d op=%0d: result=%h zero=%b want %h/%b",
                         i, ops[i], result, zero, exp[i], expz);
            end
        end
        // Equal operands compare false both ways.
        for (int op = 2; op <= 3; op++) begin
            drive(3'(op), 32'h1234_5678, 32'h1234_5678, 1'b0);
            #1;
            vectors++;
            if (result !== 32'd0 || zero !== 1'b1) begin
                errors++;
                $display("FAIL cmp_equal op=%0d: result=%h zero=%b want 0/1", op, result, zero);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        drive(3'd0, 32'd4, 32'd3, 1'b1);
        @(posedge clk);
        #1;
        vectors++;
        if (result_q !== 32'd7 || zero_q !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reg_capture: result_q=%h zero_q=%b out_valid=%b want 7/0/1",
                     result_q, zero_q, out_valid);
        end
        @(negedge clk);
        drive(3'd4, 32'd9, 32'd9, 1'b0);
        @(posedge clk);
        #1;
        vectors++;
        if (result_q !== 32'd7 || zero_q !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reg_hold: result_q=%h zero_q=%b out_valid=%b want 7/0/0",
                     result_q, zero_q, out_valid);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        drive(3'd6, 32'h5, 32'hA, 1'b1);
        @(posedge clk);
        #1;
        vectors++;
        if (result_q !== 32'hF || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_capture: result_q=%h out_valid=%b want f/1", result_q, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (result_q !== 32'd0 || zero_q !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: result_q=%h zero_q=%b out_valid=%b want 0/0/0",
                     result_q, zero_q, out_valid);
        end
        drive(3'd0, 32'd20, 32'd22, 1'b1);
        #1;
        vectors++;
        if (result !== 32'd42 || zero !== 1'b0) begin
            errors++;
            $display("FAIL comb_in_reset: result=%h zero=%b want 2a/0", result, zero);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (result_q !== 32'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL held_in_reset: result_q=%h out_valid=%b want 0/0", result_q, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'd4, 32'd10, 32'd1, 1'b1);
        @(posedge clk);
        #1;
        vectors++;
        if (result_q !== 32'd9 || zero_q !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_after_release: result_q=%h zero_q=%b out_valid=%b want 9/0/1",
                     result_q, zero_q, out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q;
        logic        exp_zq;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        logic [2:0]  op;
        logic        v;
        exp_q  = 32'd0;
        exp_zq = 1'b0;
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = 32'($urandom_range(0, 40));
                2: a = 32'hFFFFFFFF;
                default: ;
            endcase
            v = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            drive(op, a, b, v);
            #1;
            e = ref_alu(op, a, b);
            vectors++;
            if (result !== e || zero !== (e == 32'd0)) begin
                errors++;
                $display("FAIL rand_comb op=%0d a=%h b=%h: result=%h zero=%b want %h/%b",
                         op, a, b, result, zero, e, (e == 32'd0));
            end
            if (v) begin
                exp_q  = e;
                exp_zq = (e == 32'd0);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (result_q !== exp_q || zero_q !== exp_zq || out_valid !== v) begin
                errors++;
                $display("FAIL rand_reg: result_q=%h zero_q=%b out_valid=%b want %h/%b/%b",
                         result_q, zero_q, out_valid, exp_q, exp_zq, v);
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_comb_directed();
        test_registered();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the core's execute stage; selects one of eight operations via a 3-bit opcode.
- Primary result path is purely combinational: result settles within the same time step as the operands and opcode, with no clock involvement.
- A registered copy of the result, zero flag and valid (one-cycle latency) is provided for pipelined consumers.
- Uses one clock and an asynchronous active-low reset.

Parameters:
- WIDTH, 32, operand/result width; all behaviour below is specified at 32. Shift amount uses the low 5 bits.

Ports:
- clk  input  1  rising-edge clock for the registered outputs only
- rst_n  input  1  asynchronous, active-low reset for the registered outputs
- opcode  input  3  operation select
- left  input  32  operand A
- right  input  32  operand B; low 5 bits are the shift amount for shifts
- in_valid  input  1  qualifies opcode/left/right for capture into the output registers
- result  output  32  combinational result of opcode applied to left, right
- zero  output  1  combinational; 1 when result == 0
- result_q  output  32  registered result
- zero_q  output  1  registered zero
- out_valid  output  1  registered in_valid

Behaviour:
- Opcode map:
  - 000 ADD: left + right, modulo 2^32; carry discarded.
  - 001 SLL: left << right[4:0].
  - 010 SLT: signed compare; 1 if left < right (two's complement), else 0, zero-extended to 32 bits.
  - 011 SLTU: unsigned compare; 1 if left < right, else 0, zero-extended.
  - 100 SUB: left - right, modulo 2^32; borrow discarded.
  - 101 SRL: left >> right[4:0], logical, zero-fill.
  - 110 OR: left | right.
  - 111 AND: left & right.
- Combinational path:
  - result and zero are pure functions of the current opcode, left and right. No latch, no dependence on clk or rst_n.
  - Every opcode value is decoded, so no default hazard. Any X on inputs may propagate.
- Registered path:
  - Updates on the rising edge of clk.
  - out_valid <= in_valid every cycle.
  - When in_valid = 1: result_q <= result and zero_q <= zero.
  - When in_valid = 0: result_q and zero_q hold their values.
  - Latency is one cycle from the input sample to the registered outputs.
- Reset:
  - rst_n low asynchronously forces result_q = 0, zero_q = 0, out_valid = 0, regardless of clk.
  - Outputs stay in reset while rst_n is low.
  - Release is synchronous to the next rising edge: the first capture occurs on the first edge after rst_n goes high.
  - Reset mid-operation discards any pending capture. The combinational result and zero are unaffected by reset.
- Boundary conditions:
  - ADD 0xFFFFFFFF + 1 wraps to 0, so zero = 1.
  - SUB 0 - 1 = 0xFFFFFFFF.
  - Shift by 0 returns left unchanged. Shift amount bits [31:5] of right are ignored, so a shift by 32 behaves as a shift by 0.
  - SLT 0x80000000 vs 0x00000001 gives 1; SLTU on the same operands gives 0.
  - Equal operands give 0 for both SLT and SLTU.

Test Plan:
- Combinational ops, each checked 1 time unit after the inputs change, with no clock edges:
  - opcode=000, left=4, right=3 -> result=7, zero=0.
  - opcode=111, left=0b1100, right=0b1010 -> result=0b1000.
  - opcode=100, left=7, right=3 -> result=4.
- Wrap and flags:
  - ADD 0xFFFFFFFF + 1 -> result=0, zero=1.
  - SUB 3 - 3 -> result=0, zero=1.
  - SUB 0 - 1 -> result=0xFFFFFFFF, zero=0.
- Compare and shift:
  - SLT 0x80000000, 1 -> result=1.
  - SLTU 0x80000000, 1 -> result=0.
  - SLL 1 by 31 -> result=0x80000000.
  - SRL 0x80000000 by 31 -> result=1.
  - SLL 5 by right=32 -> result=5.
  - OR 0xF0, 0x0F -> result=0xFF.
- Registered path:
  - in_valid=1 with ADD 4+3 at an edge -> after that edge result_q=7, zero_q=0, out_valid=1.
  - Next cycle in_valid=0 with new operands -> result_q stays 7, out_valid=0.
- Reset:
  - Drive rst_n low between clock edges -> result_q=0, zero_q=0, out_valid=0 immediately (no edge).
  - Combinational result still tracks the inputs during reset.
  - The first capture after release happens on the first edge with rst_n high.
